// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and downstream pixel logic.
// The generator (master) drives beam position, syncs and strobes; the consumer
// (slave) drives the pixel advance enable.
interface vga_timing_gen_if;
    logic       pix_en;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic       line_start;
    logic       frame_start;
    logic [9:0] frame_count;

    modport master (
        input  pix_en,
        output hpos, vpos, hsync, vsync, display_on,
        output line_start, frame_start, frame_count
    );

    modport slave (
        output pix_en,
        input  hpos, vpos, hsync, vsync, display_on,
        input  line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator (640x480@60 Hz by default).
// Every output is a register loaded from the *next* counter values, so the
// position, syncs, active-video qualifier and strobes all describe the same
// pixel in the same clock cycle.
module vga_timing_gen #(
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    vga_timing_gen_if.master vt
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP_END   = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP_END   = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    // Map a "sync pulse active" condition onto the configured output level.
    function automatic logic sync_level(input logic active);
        sync_level = active ? SYNC_POL : ~SYNC_POL;
    endfunction

    logic [9:0] hpos_r;
    logic [9:0] vpos_r;
    logic       hsync_r;
    logic       vsync_r;
    logic       display_on_r;
    logic       line_start_r;
    logic       frame_start_r;
    logic [9:0] frame_count_r;

    logic [9:0] h_next_s;
    logic [9:0] v_next_s;
    logic       h_wrap_s;
    logic       v_wrap_s;
    logic       frame_wrap_s;
    logic       hsync_next_s;
    logic       vsync_next_s;
    logic       display_next_s;

    // Next raster position and the sync/active decode of that next position.
    always_comb begin
        h_wrap_s     = (hpos_r == H_LAST);
        v_wrap_s     = (vpos_r == V_LAST);
        frame_wrap_s = h_wrap_s && v_wrap_s;

        if (h_wrap_s) begin
            h_next_s = 10'd0;
            if (v_wrap_s) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = vpos_r + 10'd1;
            end
        end else begin
            h_next_s = hpos_r + 10'd1;
            v_next_s = vpos_r;
        end

        hsync_next_s   = sync_level((h_next_s >= H_SYNC_START) && (h_next_s < H_SYNC_END));
        vsync_next_s   = sync_level((v_next_s >= V_SYNC_START) && (v_next_s < V_SYNC_END));
        display_next_s = (h_next_s < H_DISP_END) && (v_next_s < V_DISP_END);
    end

    // Raster state: reset to (0,0); advance on pix_en; strobes last one clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_r        <= 10'd0;
            vpos_r        <= 10'd0;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            display_on_r  <= 1'b1;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_count_r <= 10'd0;
        end else begin
            // Strobes drop on the following clk even while the raster is stalled.
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            if (vt.pix_en) begin
                hpos_r        <= h_next_s;
                vpos_r        <= v_next_s;
                hsync_r       <= hsync_next_s;
                vsync_r       <= vsync_next_s;
                display_on_r  <= display_next_s;
                line_start_r  <= h_wrap_s;
                frame_start_r <= frame_wrap_s;
                if (frame_wrap_s) begin
                    frame_count_r <= frame_count_r + 10'd1;
                end else begin
                    frame_count_r <= frame_count_r;
                end
            end else begin
                hpos_r        <= hpos_r;
                vpos_r        <= vpos_r;
                hsync_r       <= hsync_r;
                vsync_r       <= vsync_r;
                display_on_r  <= display_on_r;
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign vt.hpos        = hpos_r;
    assign vt.vpos        = vpos_r;
    assign vt.hsync       = hsync_r;
    assign vt.vsync       = vsync_r;
    assign vt.display_on  = display_on_r;
    assign vt.line_start  = line_start_r;
    assign vt.frame_start = frame_start_r;
    assign vt.frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default 640x480 active-low instance and a
// tiny active-high instance (fast frames, used for the frame counter wrap).
// Expected outputs come from a pixel-count model: the number of pixel
// advances since reset determines position, frame number and sync levels.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if ifb ();

    vga_timing_gen u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .vt    (ifa)
    );

    vga_timing_gen #(
        .H_DISPLAY (4),
        .H_FRONT   (1),
        .H_SYNC    (1),
        .H_BACK    (1),
        .V_DISPLAY (2),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1),
        .SYNC_POL  (1'b1)
    ) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .vt    (ifb)
    );

    int checks = 0;
    int errors = 0;

    // Active configuration (selected instance and its raster geometry).
    int  sel;
    int  ht, vt, hd, vd, hslo, hshi, vslo, vshi;
    bit  pol;

    // Reference model state.
    longint n;
    bit     m_ls;
    bit     m_fs;
    bit     wrap_seen;
    int     prev_fc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic compare_all();
        logic [9:0] oh, ov, ofc;
        logic       ohs, ovs, od, ols, ofs;
        longint     h, v, fc;
        bit         eh, ev, ed;
        if (sel == 0) begin
            oh = ifa.hpos; ov = ifa.vpos; ofc = ifa.frame_count;
            ohs = ifa.hsync; ovs = ifa.vsync; od = ifa.display_on;
            ols = ifa.line_start; ofs = ifa.frame_start;
        end else begin
            oh = ifb.hpos; ov = ifb.vpos; ofc = ifb.frame_count;
            ohs = ifb.hsync; ovs = ifb.vsync; od = ifb.display_on;
            ols = ifb.line_start; ofs = ifb.frame_start;
        end
        h  = n % ht;
        v  = (n / ht) % vt;
        fc = (n / (ht * vt)) % 1024;
        eh = (h >= hslo && h < hshi) ? pol : !pol;
        ev = (v >= vslo && v < vshi) ? pol : !pol;
        ed = (h < hd) && (v < vd);
        check("hpos",        32'(oh),  32'(h));
        check("vpos",        32'(ov),  32'(v));
        check("hsync",       32'(ohs), 32'(eh));
        check("vsync",       32'(ovs), 32'(ev));
        check("display_on",  32'(od),  32'(ed));
        check("line_start",  32'(ols), 32'(m_ls));
        check("frame_start", 32'(ofs), 32'(m_fs));
        check("frame_count", 32'(ofc), 32'(fc));
        if (prev_fc == 1023 && ofc == 10'd0) wrap_seen = 1'b1;
        prev_fc = int'(ofc);
    endtask

    // One clock: drive inputs on the falling edge, update model, check after the edge.
    task automatic step(input logic en, input logic rst);
        @(negedge clk);
        if (sel == 0) begin
            ifa.pix_en = en;
            rst_a      = rst;
        end else begin
            ifb.pix_en = en;
            rst_b      = rst;
        end
        @(posedge clk);
        if (rst) begin
            n    = 0;
            m_ls = 1'b0;
            m_fs = 1'b0;
        end else begin
            m_ls = 1'b0;
            m_fs = 1'b0;
            if (en) begin
                n++;
                if (n % ht == 0)        m_ls = 1'b1;
                if (n % (ht * vt) == 0) m_fs = 1'b1;
            end
        end
        #1;
        compare_all();
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.pix_en = 1'b0;
        ifb.pix_en = 1'b0;
        n = 0; m_ls = 1'b0; m_fs = 1'b0;
        wrap_seen = 1'b0;
        prev_fc = 0;

        // Default 640x480, active-low syncs.
        sel = 0;
        ht = 800; vt = 525; hd = 640; vd = 480;
        hslo = 656; hshi = 752; vslo = 490; vshi = 492; pol = 1'b0;

        repeat (3) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 2500; i++) step($urandom_range(0, 99) < 85, 1'b0);

        // Stall around the end of a line.
        for (int i = 0; i < 2000 && (n % ht) != 798; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);

        // Reset in the middle of a line.
        for (int i = 0; i < 2000 && (n % ht) != 300; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step($urandom_range(0, 1) == 1, 1'b0);

        // Tiny raster, active-high syncs: run past 1024 frames.
        @(negedge clk);
        rst_a = 1'b1;
        sel = 1;
        ht = 7; vt = 6; hd = 4; vd = 2;
        hslo = 5; hshi = 6; vslo = 3; vshi = 5; pol = 1'b1;
        prev_fc = 0;
        repeat (2) step(1'b1, 1'b1);
        for (int i = 0; i < 60000 && n < 1026 * 42; i++) step($urandom_range(0, 9) != 0, 1'b0);
        check("frames_reached", (n >= 1026 * 42) ? 32'd1 : 32'd0, 32'd1);
        check("fc_wrap_seen",   32'(wrap_seen), 32'd1);

        // Reset mid-frame on the tiny raster, then resume.
        for (int i = 0; i < 100 && (n % 42) != 17; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 60; i++) step($urandom_range(0, 3) != 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
